// File: rtl/key_mode_ctrl.sv
// Two-key mode selector: synchronizes and debounces the UP/DOWN push-buttons,
// turns each press into one step (plus auto-repeat while held) and keeps a
// 2-bit wrap-around mode register with a one-cycle change strobe.
module key_mode_ctrl #(
   parameter int unsigned DEB_CYCLES    = 1_000_000,
   parameter int unsigned HOLD_CYCLES   = 50_000_000,
   parameter int unsigned REPEAT_CYCLES = 12_500_000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_key_n,
   output logic [1:0] o_mode_sw,
   output logic       o_mode_chg,
   output logic [1:0] o_key_level
);

   localparam logic [31:0] DebLast  = 32'(DEB_CYCLES - 1);
   localparam logic [31:0] HoldLast = 32'(HOLD_CYCLES - 1);
   localparam logic [31:0] RepLast  = 32'(REPEAT_CYCLES - 1);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StHold   = 2'd1;
   localparam logic [1:0] StRepeat = 2'd2;

   logic [1:0] r_sync1;
   logic [1:0] r_sync2;
   logic [1:0] w_synced;
   logic [1:0] w_key_level;
   logic [1:0] w_step;
   logic [1:0] r_mode_sw;
   logic [1:0] w_mode_d;
   logic       r_mode_chg;

   // Two-flop synchronizer; flops idle at 1 so a held key is seen as a fresh press after reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync1 <= 2'b11;
         r_sync2 <= 2'b11;
      end else begin
         r_sync1 <= i_key_n;
         r_sync2 <= r_sync1;
      end
   end

   assign w_synced = ~r_sync2;

   for (genvar k = 0; k < 2; k++) begin : g_key
      logic [31:0] r_deb_cnt;
      logic        r_level;
      logic [1:0]  r_state;
      logic [1:0]  w_state_d;
      logic [31:0] r_timer;
      logic [31:0] w_timer_d;
      logic        w_step_k;

      // Debounce: level flips only after DEB_CYCLES consecutive disagreeing samples.
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            r_deb_cnt <= '0;
            r_level   <= 1'b0;
         end else if (w_synced[k] == r_level) begin
            r_deb_cnt <= '0;
         end else if (r_deb_cnt == DebLast) begin
            r_deb_cnt <= '0;
            r_level   <= ~r_level;
         end else begin
            r_deb_cnt <= r_deb_cnt + 32'd1;
         end
      end

      // Press / hold / repeat sequencing; IDLE with level high can only follow a rising level.
      always_comb begin
         w_state_d = r_state;
         w_timer_d = r_timer;
         w_step_k  = 1'b0;
         if (!r_level) begin
            w_state_d = StIdle;
            w_timer_d = '0;
         end else begin
            case (r_state)
               StIdle: begin
                  w_step_k  = 1'b1;
                  w_state_d = StHold;
                  w_timer_d = '0;
               end
               StHold: begin
                  if (r_timer == HoldLast) begin
                     w_step_k  = 1'b1;
                     w_state_d = StRepeat;
                     w_timer_d = '0;
                  end else begin
                     w_timer_d = r_timer + 32'd1;
                  end
               end
               StRepeat: begin
                  if (r_timer == RepLast) begin
                     w_step_k  = 1'b1;
                     w_timer_d = '0;
                  end else begin
                     w_timer_d = r_timer + 32'd1;
                  end
               end
               default: begin
                  w_state_d = StIdle;
                  w_timer_d = '0;
               end
            endcase
         end
      end

      // FSM state and timer registers.
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            r_state <= StIdle;
            r_timer <= '0;
         end else begin
            r_state <= w_state_d;
            r_timer <= w_timer_d;
         end
      end

      assign w_key_level[k] = r_level;
      assign w_step[k]      = w_step_k;
   end

   // Next mode: UP increments, DOWN decrements, both together force 00.
   always_comb begin
      w_mode_d = r_mode_sw;
      case (w_step)
         2'b01:   w_mode_d = r_mode_sw + 2'd1;
         2'b10:   w_mode_d = r_mode_sw - 2'd1;
         2'b11:   w_mode_d = 2'b00;
         default: w_mode_d = r_mode_sw;
      endcase
   end

   // Mode register with a strobe that fires only on an actual value change.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mode_sw  <= 2'b00;
         r_mode_chg <= 1'b0;
      end else begin
         r_mode_sw  <= w_mode_d;
         r_mode_chg <= (w_mode_d != r_mode_sw);
      end
   end

   assign o_mode_sw   = r_mode_sw;
   assign o_mode_chg  = r_mode_chg;
   assign o_key_level = w_key_level;

endmodule

// File: doc/key_mode_ctrl.md
KEY_MODE_CTRL -- requirements
Module: key_mode_ctrl

Interface
REQ-001: The block SHALL have parameter DEB_CYCLES, default 1_000_000, giving the debounce stable-time in clk cycles (20 ms at 50 MHz); legal range 1..2^32-1.
REQ-002: The block SHALL have parameter HOLD_CYCLES, default 50_000_000, giving the continuous-press time before auto-repeat starts; legal range 1..2^32-1.
REQ-003: The block SHALL have parameter REPEAT_CYCLES, default 12_500_000, giving the auto-repeat interval; legal range 1..2^32-1.
REQ-004: clk  input  1  single system clock; all logic on its rising edge.
REQ-005: rst  input  1  asynchronous, active-high reset.
REQ-006: key_n  input  2  raw push-buttons, active-low, asynchronous to clk, may bounce; [0]=UP, [1]=DOWN.
REQ-007: mode_sw  output  2  registered mode select, consumed directly by the LED marquee stage.
REQ-008: mode_chg  output  1  registered one-cycle pulse, high in the same cycle mode_sw takes a new value.
REQ-009: key_level  output  2  registered debounced key level, 1 = pressed.

Function
REQ-010: Each key_n bit SHALL pass through a two-flop synchronizer; synced[i] = inverted second-flop output (1 = pressed).
REQ-011: Per key, a 32-bit debounce counter SHALL clear whenever synced[i] == key_level[i], and otherwise increment.
REQ-012: Per key, when synced[i] != key_level[i] and the counter equals DEB_CYCLES-1, key_level[i] SHALL toggle and the counter SHALL clear on the same edge.
REQ-013: Any bounce, meaning synced returns to key_level before the count completes, SHALL clear the counter with no level change.
REQ-014: A clean raw transition SHALL appear on key_level exactly DEB_CYCLES+2 clk edges later.
REQ-015: Per key, an FSM SHALL run with states IDLE, HOLD and REPEAT, plus a 32-bit timer.
- IDLE to HOLD: on key_level rising; issue one step event; timer cleared.
- HOLD to REPEAT: when the timer reaches HOLD_CYCLES-1; issue a step event; timer cleared.
- REPEAT: when the timer reaches REPEAT_CYCLES-1, issue a step event and clear the timer; otherwise the timer increments.
- Any state to IDLE: whenever key_level is 0, with no event.
REQ-016: A step event SHALL be registered and SHALL update mode_sw on the next clk edge: UP gives mode_sw+1 and DOWN gives mode_sw-1, both 2-bit modulo (11+1=00, 00-1=11).
REQ-017: mode_sw SHALL appear exactly DEB_CYCLES+3 edges after a clean raw press; mode_chg SHALL pulse on that same edge.
REQ-018: UP and DOWN step events in the same cycle SHALL force mode_sw to 00, and mode_chg SHALL pulse only if mode_sw was not already 00.
REQ-019: mode_chg SHALL stay low whenever mode_sw does not change value.
REQ-020: Releasing a key SHALL generate no step event.
REQ-021: While one key is in HOLD or REPEAT, a press on the other key SHALL be processed independently.

Reset
REQ-022: While rst=1, all of the following SHALL be held:
- mode_sw=00, mode_chg=0, key_level=00;
- synchronizer flops at 1 (released);
- all counters and timers at 0;
- both FSMs in IDLE.
REQ-023: Reset asserted mid-debounce or mid-repeat SHALL abort that operation; after release, a key still held SHALL be re-debounced and produce a fresh press event.
REQ-024: Outputs SHALL remain at reset values for at least DEB_CYCLES+2 cycles after rst deasserts, whatever the key_n state.

Verification (DEB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8)
REQ-025: Clean UP press from reset, key_n[0] low at edge 0 and held -> key_level[0]=1 at edge 6, mode_sw=01 with mode_chg=1 at edge 7, mode_chg=0 at edge 8.
REQ-026: Bounce: key_n[0] low 3 cycles, high 1 cycle, then low held -> no change until a full 4-cycle stable window completes; exactly one increment.
REQ-027: Wrap: four UP presses from 00 -> mode_sw sequence 01,10,11,00; a DOWN press from 00 -> 11; each change gives one mode_chg pulse.
REQ-028: Auto-repeat: UP held 60 cycles after debounce -> step events at press, +20, +28, +36, +44, +52; mode_sw advances 6 times modulo 4; release gives no step.
REQ-029: Simultaneous: UP and DOWN go low on the same edge with mode_sw=10 -> mode_sw=00 and one mode_chg pulse; repeat with mode_sw=00 -> no mode_chg.
REQ-030: Reset mid-repeat with UP held -> all outputs cleared immediately; after release, key_level[0]=1 after 6 edges and mode_sw=01 after 7.
